// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 bus arbiter with a bounded hold time; grant one edge after request, data registered one edge after grant.
// No backpressure: a requester drops req to stall, and the owner yields after MAX_HOLD words while the other requester waits.
module mux2_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int            CW       = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] hold_cnt;
    logic [1:0]    last;
    logic          hold_done;
    logic          accept;

    assign hold_done = (hold_cnt == HOLD_MAX);
    assign accept    = (gnt1 & req1) | (gnt2 & req2);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // on a tie, the requester that did not own the bus last wins
                if (req1 && req2)
                    state_nxt = (last == 2'd1) ? G2 : G1;
                else if (req1)
                    state_nxt = G1;
                else if (req2)
                    state_nxt = G2;
            end
            G1: begin
                if (!req1)
                    state_nxt = req2 ? G2 : IDLE;
                else if (req2 && hold_done)
                    state_nxt = G2;
            end
            G2: begin
                if (!req2)
                    state_nxt = req1 ? G1 : IDLE;
                else if (req1 && hold_done)
                    state_nxt = G1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt1      <= 1'b0;
            gnt2      <= 1'b0;
            sel       <= 1'b0;
            hold_cnt  <= '0;
            last      <= 2'd2;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt1  <= (state_nxt == G1);
            gnt2  <= (state_nxt == G2);
            // sel follows the new owner on the switch edge and holds through IDLE
            if (state_nxt == G2)
                sel <= 1'b1;
            else if (state_nxt == G1)
                sel <= 1'b0;

            if (state_nxt != state) begin
                hold_cnt <= '0;
                if (state != IDLE)
                    last <= (state == G1) ? 2'd1 : 2'd2;
            end else if (accept && !hold_done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (accept) begin
                out       <= sel ? in2 : in1;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
